memory_access_controller: RTL and testbench
===========================================

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset; all state SHALL change only on the rising edge of clk.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_request  in  1  fetch stage requests an instruction word
- fetch_address  in  32  instruction address
- fetch_data  out  32  registered instruction word
- fetch_valid  out  1  one-cycle pulse: fetch_data valid
- data_read_request  in  1  memory stage load
- data_write_request  in  1  memory stage store
- data_address  in  32  load/store address
- data_write_data  in  32  store data
- data_byteenable  in  4  load/store byte lanes
- data_read_data  out  32  registered load word
- data_valid  out  1  one-cycle pulse: data access complete
- HALT  in  1  halt request from the pipeline
- halted  out  1  controller is halted
- stall_fetch  out  1  hold the fetch-side pipeline registers
- stall_memory  out  1  hold the memory-stage pipeline registers
- address  out  32  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- byteenable  out  4  bus byte lanes
- writedata  out  32  bus write data
- readdata  in  32  bus read data
- waitrequest  in  1  bus not ready

Function
REQ-003 The FSM SHALL have four states: IDLE, DATA_ACCESS, FETCH_ACCESS and HALTED.
REQ-004 A data request is pending when (data_read_request | data_write_request) & ~data_valid; a fetch request is pending when fetch_request & ~fetch_valid.
REQ-005 In IDLE, a pending data request SHALL move the FSM to DATA_ACCESS, taking priority over a pending fetch.
REQ-006 In IDLE with no pending data request, a pending fetch SHALL move the FSM to FETCH_ACCESS.
REQ-007 In IDLE with no pending request and HALT=1, the FSM SHALL move to HALTED.
REQ-008 In IDLE with no pending request and HALT=0, the FSM SHALL stay in IDLE.
REQ-009 On entry to DATA_ACCESS, the block SHALL register address=data_address, byteenable=data_byteenable and writedata=data_write_data.
REQ-010 In DATA_ACCESS, the block SHALL drive write=1 if data_write_request=1, otherwise read=1; when both requests are asserted, the write wins.
REQ-011 On entry to FETCH_ACCESS, the block SHALL register address=fetch_address, byteenable=4'b1111 and read=1.
REQ-012 While waitrequest=1, address, read, write, byteenable and writedata SHALL hold stable.
REQ-013 The access SHALL complete in the first cycle in which the strobe is high and waitrequest=0.
REQ-014 In that completion cycle, readdata SHALL be captured (into data_read_data or fetch_data), the strobes SHALL drop on the next edge and the FSM SHALL return to IDLE.
REQ-015 data_valid or fetch_valid SHALL pulse for exactly the one cycle after the completion edge.
REQ-016 Minimum latency SHALL be 2 cycles from request to valid pulse; each cycle of waitrequest adds one cycle.
REQ-017 data_read_data SHALL be unchanged by a write access; fetch_data and data_read_data SHALL hold their values until the next respective read completes.
REQ-018 The strobes read and write SHALL never both be 1.
REQ-019 stall_memory SHALL be combinational and equal to the data-pending term; stall_fetch SHALL equal (fetch-pending term) | stall_memory.
REQ-020 HALT asserted during an access SHALL NOT abort it; HALTED is entered only from IDLE.
REQ-021 In HALTED, the block SHALL issue no bus strobes and ignore all requests, with halted=1; only reset leaves HALTED.
REQ-022 The block SHALL NOT issue back-to-back accesses from the same requester without an intervening IDLE cycle.

Reset
REQ-023 While reset=1 at a clock edge, the FSM SHALL go to IDLE and address, read, write, byteenable, writedata, fetch_data, fetch_valid, data_read_data, data_valid and halted SHALL all be cleared to 0.
REQ-024 Reset asserted mid-access SHALL drop read/write on that edge and discard the transaction with no valid pulse.

Verification
REQ-025 A bench SHALL cover these directed scenarios:
- fetch_request=1, fetch_address=0x00000010, waitrequest=0, readdata=0x24020005 -> read=1 at 0x10 for one cycle; fetch_valid pulse with fetch_data=0x24020005 two cycles after the request.
- data_read_request=1 and fetch_request=1 together, data_address=0x100 -> data access first, then fetch; stall_fetch=1 throughout the data access.
- data_write_request=1, data_write_data=0xDEADBEEF, data_byteenable=4'b0011, waitrequest high for 3 cycles -> write, address, writedata and byteenable stable for 4 cycles; data_valid 5 cycles after the request; data_read_data unchanged.
- HALT=1 during a pending fetch with waitrequest=1 -> fetch completes, then halted=1; a later fetch_request produces no read.
- reset=1 while read=1 and waitrequest=1 -> read=0 and all outputs 0 next cycle; no valid pulse.

Source files
------------

// File: rtl/memory_access_controller.sv
// Arbitrates instruction fetch and load/store requests onto a single
// waitrequest-style bus; data accesses win over fetches, HALT parks the FSM.
module memory_access_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_request,
   input  logic [31:0] fetch_address,
   output logic [31:0] fetch_data,
   output logic        fetch_valid,
   input  logic        data_read_request,
   input  logic        data_write_request,
   input  logic [31:0] data_address,
   input  logic [31:0] data_write_data,
   input  logic [3:0]  data_byteenable,
   output logic [31:0] data_read_data,
   output logic        data_valid,
   input  logic        HALT,
   output logic        halted,
   output logic        stall_fetch,
   output logic        stall_memory,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   input  logic        waitrequest
);
   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] DATA_ACCESS  = 2'd1;
   localparam logic [1:0] FETCH_ACCESS = 2'd2;
   localparam logic [1:0] HALTED       = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] address_q, address_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [3:0]  byteenable_q, byteenable_d;
   logic [31:0] writedata_q, writedata_d;
   logic [31:0] fetch_data_q, fetch_data_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic [31:0] data_read_data_q, data_read_data_d;
   logic        data_valid_q, data_valid_d;

   logic data_pending, fetch_pending, done;

   // Valid pulses mask the still-held request for one cycle, which also
   // guarantees an IDLE cycle between two accesses from one requester.
   assign data_pending  = (data_read_request | data_write_request) & ~data_valid_q;
   assign fetch_pending = fetch_request & ~fetch_valid_q;
   assign done          = (read_q | write_q) & ~waitrequest;

   always_comb begin
      state_d          = state_q;
      address_d        = address_q;
      read_d           = read_q;
      write_d          = write_q;
      byteenable_d     = byteenable_q;
      writedata_d      = writedata_q;
      fetch_data_d     = fetch_data_q;
      data_read_data_d = data_read_data_q;
      fetch_valid_d    = 1'b0;
      data_valid_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_pending) begin
               state_d      = DATA_ACCESS;
               address_d    = data_address;
               byteenable_d = data_byteenable;
               writedata_d  = data_write_data;
               write_d      = data_write_request;
               read_d       = ~data_write_request;
            end else if (fetch_pending) begin
               state_d      = FETCH_ACCESS;
               address_d    = fetch_address;
               byteenable_d = 4'b1111;
               read_d       = 1'b1;
               write_d      = 1'b0;
            end else if (HALT) begin
               state_d = HALTED;
            end
         end
         DATA_ACCESS: begin
            if (done) begin
               state_d      = IDLE;
               read_d       = 1'b0;
               write_d      = 1'b0;
               data_valid_d = 1'b1;
               if (read_q) data_read_data_d = readdata;
            end
         end
         FETCH_ACCESS: begin
            if (done) begin
               state_d       = IDLE;
               read_d        = 1'b0;
               write_d       = 1'b0;
               fetch_valid_d = 1'b1;
               fetch_data_d  = readdata;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         address_q        <= '0;
         read_q           <= 1'b0;
         write_q          <= 1'b0;
         byteenable_q     <= '0;
         writedata_q      <= '0;
         fetch_data_q     <= '0;
         fetch_valid_q    <= 1'b0;
         data_read_data_q <= '0;
         data_valid_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         address_q        <= address_d;
         read_q           <= read_d;
         write_q          <= write_d;
         byteenable_q     <= byteenable_d;
         writedata_q      <= writedata_d;
         fetch_data_q     <= fetch_data_d;
         fetch_valid_q    <= fetch_valid_d;
         data_read_data_q <= data_read_data_d;
         data_valid_q     <= data_valid_d;
      end
   end

   assign address        = address_q;
   assign read           = read_q;
   assign write          = write_q;
   assign byteenable     = byteenable_q;
   assign writedata      = writedata_q;
   assign fetch_data     = fetch_data_q;
   assign fetch_valid    = fetch_valid_q;
   assign data_read_data = data_read_data_q;
   assign data_valid     = data_valid_q;
   assign halted         = (state_q == HALTED);
   assign stall_memory   = data_pending;
   assign stall_fetch    = fetch_pending | data_pending;
endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_memory_access_controller;
   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_request;
   logic [31:0] fetch_address;
   logic [31:0] fetch_data;
   logic        fetch_valid;
   logic        data_read_request;
   logic        data_write_request;
   logic [31:0] data_address;
   logic [31:0] data_write_data;
   logic [3:0]  data_byteenable;
   logic [31:0] data_read_data;
   logic        data_valid;
   logic        HALT;
   logic        halted;
   logic        stall_fetch;
   logic        stall_memory;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   memory_access_controller dut (
      .clk(clk), .reset(reset),
      .fetch_request(fetch_request), .fetch_address(fetch_address),
      .fetch_data(fetch_data), .fetch_valid(fetch_valid),
      .data_read_request(data_read_request), .data_write_request(data_write_request),
      .data_address(data_address), .data_write_data(data_write_data),
      .data_byteenable(data_byteenable), .data_read_data(data_read_data),
      .data_valid(data_valid), .HALT(HALT), .halted(halted),
      .stall_fetch(stall_fetch), .stall_memory(stall_memory),
      .address(address), .read(read), .write(write), .byteenable(byteenable),
      .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_request = 0; fetch_address = 0; data_read_request = 0;
      data_write_request = 0; data_address = 0; data_write_data = 0;
      data_byteenable = 0; HALT = 0; readdata = 0; waitrequest = 0;
      step();
      step();
      reset = 1'b0;
      vecs++;
      if ({address, writedata, byteenable} !== 68'd0) begin
         errs++; $display("FAIL reset_bus got addr=%h wd=%h be=%h exp 0", address, writedata, byteenable);
      end
      vecs++;
      if ({read, write, fetch_valid, data_valid, halted, stall_fetch, stall_memory} !== 7'd0) begin
         errs++; $display("FAIL reset_flags got r=%b w=%b fv=%b dv=%b h=%b exp all 0", read, write, fetch_valid, data_valid, halted);
      end
      vecs++;
      if ({fetch_data, data_read_data} !== 64'd0) begin
         errs++; $display("FAIL reset_data got fd=%h dr=%h exp 0", fetch_data, data_read_data);
      end
   endtask

   task automatic test_fetch();
      fetch_request = 1; fetch_address = 32'h10; readdata = 32'h24020005; waitrequest = 0;
      #1;
      vecs++;
      if ({stall_fetch, stall_memory} !== 2'b10) begin
         errs++; $display("FAIL fetch_stall got sf=%b sm=%b exp 1 0", stall_fetch, stall_memory);
      end
      step();
      vecs++;
      if ({read, write, address, byteenable, fetch_valid} !== {1'b1, 1'b0, 32'h10, 4'hF, 1'b0}) begin
         errs++; $display("FAIL fetch_issue got r=%b w=%b a=%h be=%h fv=%b exp 1 0 10 f 0", read, write, address, byteenable, fetch_valid);
      end
      step();
      vecs++;
      if ({read, fetch_valid, fetch_data} !== {1'b0, 1'b1, 32'h24020005}) begin
         errs++; $display("FAIL fetch_done got r=%b fv=%b fd=%h exp 0 1 24020005", read, fetch_valid, fetch_data);
      end
      vecs++;
      if (stall_fetch !== 1'b0) begin
         errs++; $display("FAIL fetch_stall_release got %b exp 0", stall_fetch);
      end
      fetch_request = 0;
      step();
      vecs++;
      if ({read, fetch_valid, fetch_data} !== {1'b0, 1'b0, 32'h24020005}) begin
         errs++; $display("FAIL fetch_pulse_end got r=%b fv=%b fd=%h exp 0 0 24020005", read, fetch_valid, fetch_data);
      end
   endtask

   task automatic test_priority();
      data_read_request = 1; fetch_request = 1; data_address = 32'h100; fetch_address = 32'h20;
      data_byteenable = 4'hF; readdata = 32'h11111111; waitrequest = 0;
      #1;
      vecs++;
      if ({stall_fetch, stall_memory} !== 2'b11) begin
         errs++; $display("FAIL prio_stall_req got sf=%b sm=%b exp 1 1", stall_fetch, stall_memory);
      end
      step();
      vecs++;
      if ({read, write, address, stall_fetch} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
         errs++; $display("FAIL prio_data_first got r=%b w=%b a=%h sf=%b exp 1 0 100 1", read, write, address, stall_fetch);
      end
      step();
      vecs++;
      if ({read, data_valid, data_read_data, fetch_valid} !== {1'b0, 1'b1, 32'h11111111, 1'b0}) begin
         errs++; $display("FAIL prio_data_done got r=%b dv=%b dr=%h fv=%b exp 0 1 11111111 0", read, data_valid, data_read_data, fetch_valid);
      end
      vecs++;
      if ({stall_fetch, stall_memory} !== 2'b10) begin
         errs++; $display("FAIL prio_stall_after got sf=%b sm=%b exp 1 0", stall_fetch, stall_memory);
      end
      data_read_request = 0; readdata = 32'h22222222;
      step();
      vecs++;
      if ({read, address, byteenable, data_valid} !== {1'b1, 32'h20, 4'hF, 1'b0}) begin
         errs++; $display("FAIL prio_fetch_issue got r=%b a=%h be=%h dv=%b exp 1 20 f 0", read, address, byteenable, data_valid);
      end
      step();
      vecs++;
      if ({read, fetch_valid, fetch_data} !== {1'b0, 1'b1, 32'h22222222}) begin
         errs++; $display("FAIL prio_fetch_done got r=%b fv=%b fd=%h exp 0 1 22222222", read, fetch_valid, fetch_data);
      end
      fetch_request = 0;
      step();
   endtask

   task automatic test_write_wait();
      data_write_request = 1; data_write_data = 32'hDEADBEEF; data_byteenable = 4'b0011;
      data_address = 32'h200; waitrequest = 1; readdata = 32'hCAFEF00D;
      for (int i = 1; i <= 4; i++) begin
         step();
         vecs++;
         if ({write, read, address, writedata, byteenable, data_valid} !==
             {1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 4'b0011, 1'b0}) begin
            errs++; $display("FAIL write_hold[%0d] got w=%b r=%b a=%h wd=%h be=%h dv=%b exp 1 0 200 deadbeef 3 0",
                             i, write, read, address, writedata, byteenable, data_valid);
         end
         if (i == 4) waitrequest = 0;
      end
      step();
      vecs++;
      if ({write, data_valid, data_read_data} !== {1'b0, 1'b1, 32'h11111111}) begin
         errs++; $display("FAIL write_done got w=%b dv=%b dr=%h exp 0 1 11111111", write, data_valid, data_read_data);
      end
      data_write_request = 0;
      step();
      vecs++;
      if ({write, data_valid} !== 2'b00) begin
         errs++; $display("FAIL write_pulse_end got w=%b dv=%b exp 0 0", write, data_valid);
      end
   endtask

   task automatic test_halt();
      fetch_request = 1; fetch_address = 32'h30; waitrequest = 1; readdata = 32'h33333333;
      step();
      HALT = 1;
      step();
      vecs++;
      if ({read, halted, address} !== {1'b1, 1'b0, 32'h30}) begin
         errs++; $display("FAIL halt_no_abort got r=%b h=%b a=%h exp 1 0 30", read, halted, address);
      end
      waitrequest = 0;
      step();
      vecs++;
      if ({read, fetch_valid, fetch_data, halted} !== {1'b0, 1'b1, 32'h33333333, 1'b0}) begin
         errs++; $display("FAIL halt_fetch_done got r=%b fv=%b fd=%h h=%b exp 0 1 33333333 0", read, fetch_valid, fetch_data, halted);
      end
      fetch_request = 0;
      step();
      vecs++;
      if (halted !== 1'b1) begin
         errs++; $display("FAIL halt_enter got %b exp 1", halted);
      end
      HALT = 0; fetch_request = 1; fetch_address = 32'h40;
      for (int i = 0; i < 3; i++) begin
         step();
         vecs++;
         if ({read, write, halted, fetch_valid} !== 4'b0010) begin
            errs++; $display("FAIL halt_ignore[%0d] got r=%b w=%b h=%b fv=%b exp 0 0 1 0", i, read, write, halted, fetch_valid);
         end
      end
      fetch_request = 0;
   endtask

   task automatic test_reset_mid_access();
      reset = 1;
      step();
      reset = 0;
      vecs++;
      if (halted !== 1'b0) begin
         errs++; $display("FAIL rst_leave_halt got %b exp 0", halted);
      end
      fetch_request = 1; fetch_address = 32'h50; waitrequest = 1; readdata = 32'h55555555;
      step();
      vecs++;
      if ({read, address} !== {1'b1, 32'h50}) begin
         errs++; $display("FAIL rst_mid_issue got r=%b a=%h exp 1 50", read, address);
      end
      reset = 1;
      step();
      vecs++;
      if ({read, write, address, byteenable, writedata, fetch_valid, data_valid, halted} !== 72'd0) begin
         errs++; $display("FAIL rst_mid_clear got r=%b w=%b a=%h be=%h wd=%h fv=%b dv=%b exp all 0",
                          read, write, address, byteenable, writedata, fetch_valid, data_valid);
      end
      vecs++;
      if ({fetch_data, data_read_data} !== 64'd0) begin
         errs++; $display("FAIL rst_mid_data got fd=%h dr=%h exp 0", fetch_data, data_read_data);
      end
      reset = 0; fetch_request = 0; waitrequest = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         vecs++;
         if ({read, fetch_valid} !== 2'b00) begin
            errs++; $display("FAIL rst_mid_no_pulse[%0d] got r=%b fv=%b exp 0 0", i, read, fetch_valid);
         end
      end
   endtask

   // Bus strobes must be mutually exclusive at every sample point.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         vecs++;
         if ((read & write) !== 1'b0) begin
            errs++; $display("FAIL strobe_exclusive got r=%b w=%b exp not both 1", read, write);
         end
      end
   end

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_write_wait();
      test_halt();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
